// File: rtl/dac_wave_gen_if.sv
// Bus between the sound controller and dac_wave_gen: tick/handshake inputs, DAC code and status back.
interface dac_wave_gen_if #(
   parameter int N  = 8,
   parameter int LW = 8
);
   logic          at_max;
   logic          start;
   logic          stop;
   logic [1:0]    mode;
   logic [N-1:0]  step;
   logic [LW-1:0] burst_len;
   logic [N-1:0]  dacCount;
   logic          busy;
   logic          done;

   modport master (
      output at_max, start, stop, mode, step, burst_len,
      input  dacCount, busy, done
   );

   modport slave (
      input  at_max, start, stop, mode, step, burst_len,
      output dacCount, busy, done
   );
endinterface

// File: rtl/dac_wave_gen.sv
// Multi-mode DAC waveform generator (saw/triangle/square/hold) advancing one sample per at_max tick,
// with bounded-burst or continuous play and a start/stop/done handshake.
module dac_wave_gen #(
   parameter int N  = 8,
   parameter int LW = 8
) (
   input logic            clk,
   input logic            nRst,
   dac_wave_gen_if.slave  bus
);
   typedef enum logic { IDLE, RUN } state_t;
   typedef enum logic [1:0] { SAW = 2'b00, TRI = 2'b01, SQR = 2'b10, HOLD = 2'b11 } mode_t;

   localparam logic [N-1:0] MAX = '1;

   state_t        state;
   mode_t         mode_l;
   logic [N-1:0]  step_l;
   logic [LW-1:0] len_l;
   logic [N-1:0]  acc;
   logic [N-1:0]  phase;
   logic          level;
   logic          dir_up;
   logic [LW-1:0] cnt;
   logic [N-1:0]  dac_q;
   logic          busy_q;
   logic          done_q;

   logic [N:0]    acc_sum;
   logic [N:0]    ph_sum;
   logic [N-1:0]  acc_nx;
   logic [N-1:0]  phase_nx;
   logic          level_nx;
   logic          dir_nx;
   logic [N-1:0]  dac_nx;
   logic [LW-1:0] cnt_nx;
   logic          burst_end;

   assign bus.dacCount = dac_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   always_comb begin
      acc_sum   = {1'b0, acc} + {1'b0, step_l};
      ph_sum    = {1'b0, phase} + {1'b0, step_l};
      acc_nx    = acc;
      phase_nx  = phase;
      level_nx  = level;
      dir_nx    = dir_up;
      dac_nx    = dac_q;
      cnt_nx    = cnt + 1'b1;
      burst_end = (len_l != '0) && (cnt_nx == len_l);
      case (mode_l)
         SAW: begin
            acc_nx = acc_sum[N-1:0];
            dac_nx = acc_nx;
         end
         TRI: begin
            // Both turn-around points clamp to the rail rather than reflecting the overshoot.
            if (dir_up) begin
               if (acc_sum >= {1'b0, MAX}) begin
                  acc_nx = MAX;
                  dir_nx = 1'b0;
               end else begin
                  acc_nx = acc_sum[N-1:0];
               end
            end else if (acc <= step_l) begin
               acc_nx = '0;
               dir_nx = 1'b1;
            end else begin
               acc_nx = acc - step_l;
            end
            dac_nx = acc_nx;
         end
         SQR: begin
            phase_nx = ph_sum[N-1:0];
            level_nx = level ^ ph_sum[N];
            dac_nx   = level_nx ? MAX : '0;
         end
         default: dac_nx = step_l;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state  <= IDLE;
         mode_l <= SAW;
         step_l <= '0;
         len_l  <= '0;
         acc    <= '0;
         phase  <= '0;
         level  <= 1'b0;
         dir_up <= 1'b1;
         cnt    <= '0;
         dac_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            if (state == RUN) begin
               state  <= IDLE;
               dac_q  <= '0;
               busy_q <= 1'b0;
            end
         end else if (bus.start) begin
            state  <= RUN;
            mode_l <= mode_t'(bus.mode);
            step_l <= bus.step;
            len_l  <= bus.burst_len;
            acc    <= '0;
            phase  <= '0;
            level  <= 1'b0;
            dir_up <= 1'b1;
            cnt    <= '0;
            dac_q  <= (mode_t'(bus.mode) == HOLD) ? bus.step : '0;
            busy_q <= 1'b1;
         end else if (bus.at_max && state == RUN) begin
            cnt <= cnt_nx;
            if (burst_end) begin
               state  <= IDLE;
               dac_q  <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               acc    <= acc_nx;
               phase  <= phase_nx;
               level  <= level_nx;
               dir_up <= dir_nx;
               dac_q  <= dac_nx;
            end
         end
      end
   end
endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen: integer reference model checked every cycle plus literal expectations.
module tb_dac_wave_gen;
   localparam int N  = 8;
   localparam int LW = 8;

   logic clk;
   logic nRst;
   int   checks;
   int   errors;
   bit   model_on;

   dac_wave_gen_if #(.N(N), .LW(LW)) bus ();

   dac_wave_gen #(.N(N), .LW(LW)) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: waveform rules applied with plain integer arithmetic.
   int run, acc, ph, lvl, up, cnt, m_mode, m_step, m_len;
   int e_dac, e_busy, e_done;

   always @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         run = 0; acc = 0; ph = 0; lvl = 0; up = 1; cnt = 0;
         m_mode = 0; m_step = 0; m_len = 0;
         e_dac = 0; e_busy = 0; e_done = 0;
      end else begin
         e_done = 0;
         if (bus.stop) begin
            if (run != 0) begin
               run = 0; e_dac = 0; e_busy = 0;
            end
         end else if (bus.start) begin
            m_mode = int'(bus.mode); m_step = int'(bus.step); m_len = int'(bus.burst_len);
            acc = 0; ph = 0; lvl = 0; up = 1; cnt = 0;
            run = 1; e_busy = 1;
            e_dac = (m_mode == 3) ? m_step : 0;
         end else if (bus.at_max && run != 0) begin
            cnt = (cnt + 1) % 256;
            if (m_len != 0 && cnt == m_len) begin
               run = 0; e_dac = 0; e_busy = 0; e_done = 1;
            end else begin
               case (m_mode)
                  0: begin acc = (acc + m_step) % 256; e_dac = acc; end
                  1: begin
                     if (up != 0) begin
                        if (acc + m_step >= 255) begin acc = 255; up = 0; end
                        else acc = acc + m_step;
                     end else begin
                        if (acc <= m_step) begin acc = 0; up = 1; end
                        else acc = acc - m_step;
                     end
                     e_dac = acc;
                  end
                  2: begin
                     ph = ph + m_step;
                     if (ph >= 256) begin ph = ph - 256; lvl = 1 - lvl; end
                     e_dac = (lvl != 0) ? 255 : 0;
                  end
                  default: e_dac = m_step;
               endcase
            end
         end
      end
   end

   always @(negedge clk) begin
      if (nRst && model_on) begin
         check("model_dac",  int'(bus.dacCount), e_dac);
         check("model_busy", int'(bus.busy),     e_busy);
         check("model_done", int'(bus.done),     e_done);
      end
   end

   task automatic start_run(input int m, input int s, input int l);
      @(negedge clk);
      bus.mode = 2'(m); bus.step = 8'(s); bus.burst_len = 8'(l); bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      // Scramble the config inputs; the running burst must keep its latched copy.
      bus.mode = 2'(m + 1); bus.step = 8'(s + 37); bus.burst_len = 8'(l + 3);
   endtask

   task automatic pulse(input bit s, input bit t, input bit a);
      @(negedge clk);
      bus.start = s; bus.stop = t; bus.at_max = a;
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0; bus.at_max = 1'b0;
   endtask

   task automatic tick_chk(input string nm, input int exp);
      pulse(1'b0, 1'b0, 1'b1);
      check(nm, int'(bus.dacCount), exp);
   endtask

   initial begin
      checks = 0; errors = 0; model_on = 1'b0;
      nRst = 1'b0;
      bus.at_max = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
      bus.mode = 2'd0; bus.step = 8'd0; bus.burst_len = 8'd0;
      repeat (2) @(negedge clk);
      nRst = 1'b1;
      model_on = 1'b1;
      check("rst_dac",  int'(bus.dacCount), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);

      // Saw, continuous
      start_run(0, 64, 0);
      check("saw_start_dac", int'(bus.dacCount), 0);
      check("saw_start_busy", int'(bus.busy), 1);
      tick_chk("saw1", 64);  tick_chk("saw2", 128); tick_chk("saw3", 192);
      tick_chk("saw4", 0);   tick_chk("saw5", 64);
      check("saw_busy", int'(bus.busy), 1);

      // Triangle, continuous
      start_run(1, 100, 0);
      tick_chk("tri1", 100); tick_chk("tri2", 200); tick_chk("tri3", 255);
      tick_chk("tri4", 155); tick_chk("tri5", 55);  tick_chk("tri6", 0);
      tick_chk("tri7", 100);

      // Square
      start_run(2, 128, 0);
      tick_chk("sq1", 0); tick_chk("sq2", 255); tick_chk("sq3", 255);
      tick_chk("sq4", 0); tick_chk("sq5", 0);

      // Bounded burst of 4 ticks
      start_run(0, 1, 4);
      tick_chk("burst1", 1); tick_chk("burst2", 2); tick_chk("burst3", 3);
      tick_chk("burst_end_dac", 0);
      check("burst_end_done", int'(bus.done), 1);
      check("burst_end_busy", int'(bus.busy), 0);
      @(negedge clk);
      check("burst_done_once", int'(bus.done), 0);
      tick_chk("idle_tick", 0);
      check("idle_tick_done", int'(bus.done), 0);

      // Arbitration
      start_run(0, 1, 0);
      tick_chk("arb1", 1); tick_chk("arb2", 2); tick_chk("arb3", 3);
      pulse(1'b0, 1'b1, 1'b0);
      check("stop_dac", int'(bus.dacCount), 0);
      check("stop_busy", int'(bus.busy), 0);
      check("stop_done", int'(bus.done), 0);
      bus.mode = 2'd0; bus.step = 8'd1; bus.burst_len = 8'd0;
      pulse(1'b1, 1'b1, 1'b0);
      check("startstop_busy", int'(bus.busy), 0);
      pulse(1'b1, 1'b0, 1'b1);
      check("start_tick_dac", int'(bus.dacCount), 0);
      check("start_tick_busy", int'(bus.busy), 1);
      tick_chk("start_tick_next", 1);
      bus.mode = 2'd0; bus.step = 8'd7;
      pulse(1'b1, 1'b0, 1'b0);
      tick_chk("restart1", 7);

      // Hold and step=0 with a burst still counting
      start_run(3, 8'hA5, 0);
      check("hold_dac", int'(bus.dacCount), 8'hA5);
      tick_chk("hold_tick", 8'hA5);
      start_run(1, 0, 2);
      tick_chk("zstep1", 0);
      tick_chk("zstep_end", 0);
      check("zstep_done", int'(bus.done), 1);

      // Asynchronous reset mid-burst
      start_run(0, 64, 0);
      tick_chk("pre_rst1", 64); tick_chk("pre_rst2", 128);
      #2 nRst = 1'b0;
      #1;
      check("async_rst_dac", int'(bus.dacCount), 0);
      check("async_rst_busy", int'(bus.busy), 0);
      check("async_rst_done", int'(bus.done), 0);
      @(negedge clk);
      nRst = 1'b1;
      tick_chk("post_rst1", 0); tick_chk("post_rst2", 0);
      check("post_rst_busy", int'(bus.busy), 0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach its end, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/dac_wave_gen.md
Name: dac_wave_gen

Overview:
- Parametrised multi-mode successor to the simple DAC tick counter for the game's audio path.
- On each sample tick (at_max) from the prescaler, generates the next DAC code for one of four waveform modes: sawtooth, triangle, square or hold.
- Runs either a bounded burst, for sound effects, or continuous play, with a start/stop handshake and a done pulse back to the sound controller.

Parameters:
N, 8, DAC sample width in bits; MAX = 2^N-1
LW, 8, burst length counter width in bits

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
at_max  in  1  single-cycle sample tick strobe from prescaler
start  in  1  single-cycle pulse; latch mode/step/burst_len and begin (or restart) a burst
stop  in  1  single-cycle pulse; abort the burst
mode  in  2  00 saw, 01 triangle, 10 square, 11 hold
step  in  N  per-tick increment (saw/triangle), phase increment (square), or output level (hold)
burst_len  in  LW  ticks per burst; 0 = continuous
dacCount  out  N  registered DAC code
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at natural burst completion

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (async, on nRst low, no clock needed):
  - dacCount=0, busy=0, done=0.
  - FSM=IDLE, accumulator=0, phase=0, square level=0, triangle dir=up, tick count=0.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop, or on the final burst tick.
  - RUN + start -> RUN (restart).
- Priority per cycle: stop > start > at_max.
  - stop in RUN: next cycle dacCount=0, busy=0, done stays 0.
  - stop in IDLE: no effect.
  - start and stop in the same cycle: stop wins, block ends/stays IDLE.
  - start with at_max in the same cycle: the tick is ignored.
- start, one cycle latency:
  - Latch mode, step, burst_len.
  - Clear accumulator, phase, level, tick count; dir=up; busy=1.
  - dacCount=step if mode=hold, else 0.
  - mode/step/burst_len changes while busy are ignored until the next start.
- Each at_max in RUN increments the tick count (LW bits).
  - If burst_len!=0 and the new count == burst_len: dacCount=0, busy=0, done=1 for exactly one cycle, FSM=IDLE.
  - Otherwise the waveform advances and dacCount updates on the following edge (1-cycle latency from tick).
  - burst_len=0: the count never terminates the burst; wrap of the count is harmless.
- Waveform advance per mode:
  - saw: acc = (acc+step) mod 2^N; wraps silently.
  - triangle, up: sum = acc+step in N+1 bits; if sum>=MAX then acc=MAX, dir=down; else acc=sum.
  - triangle, down: if acc<=step then acc=0, dir=up; else acc=acc-step.
  - square: phase = phase+step in N+1 bits. On carry-out the level toggles. dacCount = level ? MAX : 0.
  - hold: dacCount stays at the latched step.
- step=0: saw/triangle hold the current value, square never toggles; the burst count still advances.
- at_max in IDLE: ignored, and dacCount holds.
- done is never asserted on stop, restart or reset.
- Sample values (saw/triangle/square) are output as dacCount = acc / level mapping, registered.
- No combinational path from any input to any output.

Test Plan:
1. N=8, mode=saw, step=64, burst_len=0, start then 5 ticks -> dacCount 64,128,192,0,64; busy stays 1; done never 1.
2. mode=triangle, step=100, continuous, 7 ticks -> 100,200,255,155,55,0,100.
3. mode=square, step=128, 5 ticks -> 0,255,255,0,0.
4. mode=saw, step=1, burst_len=4, 4 ticks -> 1,2,3 then 0 with done=1 for one cycle and busy=0; further ticks leave dacCount=0, done=0.
5. Arbitration on saw:
   - stop at dacCount=3 -> next cycle dacCount=0, busy=0, done=0.
   - start+stop in the same cycle -> stays IDLE.
   - start+at_max in the same cycle -> dacCount=0, busy=1, first advance only on the next tick.
   - mode=hold, step=0xA5 -> dacCount=0xA5 one cycle after start.
6. Drop nRst mid-burst between clock edges -> dacCount=0, busy=0, done=0 immediately. After release, ticks without start leave dacCount=0.
